hram_target: RTL and testbench

HRAM_TARGET -- requirements
Module: hram_target

---
 rtl/hram_target.sv | 231 +++++++++++++++++++++++
 tb/tb_hram_target.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hram_target.sv
// hram_target: HyperBus RAM target model with a small internal word memory.
// The whole bus is sampled on the system clock. CK transitions are found by
// comparing hram_ck with its registered copy, and both CK edges carry data.
// A transaction runs through six command/address edges, then a fixed 2x
// initial latency, then a read or write burst. Raising CS ends the burst.
// Ports:
//   clk            system clock; the initiator drives the bus from it too
//   reset          synchronous, active high
//   hram_ck        HyperBus CK level
//   hram_cs        chip select, active low
//   hram_rwds_*    RWDS sample / drive value / output enable
//   hram_dq_*      DQ sample / drive value / output enable
//   busy           transaction in progress
//   done           one-cycle pulse when a read or write burst ends
module hram_target #(
  parameter int          ADDR_BITS = 8,
  parameter int          LATENCY   = 6,
  parameter logic [15:0] ID0       = 16'h0C81
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hram_ck,
  input  logic       hram_cs,
  input  logic       hram_rwds_din,
  output logic       hram_rwds_dout,
  output logic       hram_rwds_dir,
  input  logic [7:0] hram_dq_din,
  output logic [7:0] hram_dq_dout,
  output logic       hram_dq_dir,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CA   = 3'd1,
    ST_LAT  = 3'd2,
    ST_RD   = 3'd3,
    ST_WR   = 3'd4
  } state_t;

  localparam int                CNT_W    = $clog2(4 * LATENCY + 1);
  localparam logic [CNT_W-1:0]  CA_LAST  = CNT_W'(5);
  localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(4 * LATENCY - 1);
  localparam logic [ADDR_BITS-1:0] ONE_A = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] LOW_A = ADDR_BITS'(15);

  state_t                 state_q, state_d;
  logic                   ck_q;
  logic                   wait_cs_q, wait_cs_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [47:0]            ca_q, ca_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             dq_dout_q, dq_dout_d;
  logic                   dq_dir_q, dq_dir_d;
  logic                   rwds_dout_q, rwds_dout_d;
  logic                   rwds_dir_q, rwds_dir_d;
  logic                   done_q, done_d;
  logic [15:0]            mem [2**ADDR_BITS];

  logic                   edge_s, rise_s;
  logic [47:0]            ca_shift_s;
  logic [15:0]            rd_word_s;
  logic [ADDR_BITS-1:0]   inc_s, next_addr_s;
  logic                   wr_hi_s, wr_lo_s;

  // Word address is {CA[44:16], CA[2:0]}, truncated to the memory depth.
  function automatic logic [ADDR_BITS-1:0] ca_addr(input logic [47:0] ca);
    logic [31:0] full;
    full = {ca[44:16], ca[2:0]};
    return full[ADDR_BITS-1:0];
  endfunction

  assign edge_s      = (hram_ck != ck_q) && !hram_cs;
  assign rise_s      = edge_s && hram_ck;
  assign ca_shift_s  = {ca_q[39:0], hram_dq_din};
  assign rd_word_s   = ca_q[46] ? ID0 : mem[addr_q];
  assign inc_s       = addr_q + ONE_A;
  // Wrapped bursts only step the low four address bits (16-word group).
  assign next_addr_s = ca_q[45] ? inc_s : ((addr_q & ~LOW_A) | (inc_s & LOW_A));

  // Next-state, counters, address and registered-output values.
  always_comb begin
    state_d     = state_q;
    wait_cs_d   = hram_cs ? 1'b0 : wait_cs_q;
    cnt_d       = cnt_q;
    ca_d        = ca_q;
    addr_d      = addr_q;
    dq_dout_d   = dq_dout_q;
    rwds_dout_d = rwds_dout_q;
    done_d      = 1'b0;
    wr_hi_s     = 1'b0;
    wr_lo_s     = 1'b0;

    if ((state_q != ST_IDLE) && hram_cs) begin
      // CS high ends any transaction; only a started burst reports done.
      state_d     = ST_IDLE;
      done_d      = (state_q == ST_RD) || (state_q == ST_WR);
      dq_dout_d   = 8'h00;
      rwds_dout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dq_dout_d = 8'h00;
          if (!hram_cs && !wait_cs_q) begin
            state_d     = ST_CA;
            cnt_d       = '0;
            rwds_dout_d = 1'b1;
          end else begin
            rwds_dout_d = 1'b0;
          end
        end
        ST_CA: begin
          rwds_dout_d = 1'b1;
          if (edge_s) begin
            ca_d = ca_shift_s;
            if (cnt_q == CA_LAST) begin
              state_d     = ST_LAT;
              cnt_d       = '0;
              addr_d      = ca_addr(ca_shift_s);
              rwds_dout_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_LAT: begin
          if (edge_s) begin
            if (cnt_q == LAT_LAST) begin
              cnt_d = '0;
              if (ca_q[47]) begin
                // Preload the first high byte so it is valid before RWDS rises.
                state_d     = ST_RD;
                dq_dout_d   = rd_word_s[15:8];
                rwds_dout_d = 1'b0;
              end else begin
                state_d = ST_WR;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RD: begin
          if (edge_s) begin
            if (rise_s) begin
              dq_dout_d   = rd_word_s[15:8];
              rwds_dout_d = 1'b1;
            end else begin
              dq_dout_d   = rd_word_s[7:0];
              rwds_dout_d = 1'b0;
              addr_d      = next_addr_s;
            end
          end else begin
            addr_d = addr_q;
          end
        end
        ST_WR: begin
          if (edge_s) begin
            // RWDS high masks the byte; register space discards writes.
            if (rise_s) begin
              wr_hi_s = !hram_rwds_din && !ca_q[46];
            end else begin
              wr_lo_s = !hram_rwds_din && !ca_q[46];
              addr_d  = next_addr_s;
            end
          end else begin
            addr_d = addr_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    dq_dir_d   = (state_d == ST_RD);
    rwds_dir_d = (state_d == ST_CA) || (state_d == ST_RD);
  end

  // State, CK history and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ck_q        <= 1'b1;
      wait_cs_q   <= 1'b1;
      cnt_q       <= '0;
      ca_q        <= '0;
      addr_q      <= '0;
      dq_dout_q   <= 8'h00;
      dq_dir_q    <= 1'b0;
      rwds_dout_q <= 1'b0;
      rwds_dir_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ck_q        <= hram_ck;
      wait_cs_q   <= wait_cs_d;
      cnt_q       <= cnt_d;
      ca_q        <= ca_d;
      addr_q      <= addr_d;
      dq_dout_q   <= dq_dout_d;
      dq_dir_q    <= dq_dir_d;
      rwds_dout_q <= rwds_dout_d;
      rwds_dir_q  <= rwds_dir_d;
      done_q      <= done_d;
    end
  end

  // Byte-lane memory writes; contents survive reset, and a reset cycle never writes.
  always_ff @(posedge clk) begin
    if (!reset && wr_hi_s) begin
      mem[addr_q][15:8] <= hram_dq_din;
    end
    if (!reset && wr_lo_s) begin
      mem[addr_q][7:0] <= hram_dq_din;
    end
  end

  assign hram_dq_dout   = dq_dout_q;
  assign hram_dq_dir    = dq_dir_q;
  assign hram_rwds_dout = rwds_dout_q;
  assign hram_rwds_dir  = rwds_dir_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_hram_target.sv
// Directed bench for hram_target: HyperBus write/read bursts, byte masking,
// wrapped/linear address wrap, register space, CS abort and mid-burst reset.
module tb_hram_target;

  localparam int LAT = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       hram_ck;
  logic       hram_cs;
  logic       hram_rwds_din;
  logic       hram_rwds_dout;
  logic       hram_rwds_dir;
  logic [7:0] hram_dq_din;
  logic [7:0] hram_dq_dout;
  logic       hram_dq_dir;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0]  wb [8];
  logic        wm [8];
  logic [15:0] ew [4];

  hram_target #(.ADDR_BITS(8), .LATENCY(LAT), .ID0(16'h0C81)) dut (
    .clk            (clk),
    .reset          (reset),
    .hram_ck        (hram_ck),
    .hram_cs        (hram_cs),
    .hram_rwds_din  (hram_rwds_din),
    .hram_rwds_dout (hram_rwds_dout),
    .hram_rwds_dir  (hram_rwds_dir),
    .hram_dq_din    (hram_dq_din),
    .hram_dq_dout   (hram_dq_dout),
    .hram_dq_dir    (hram_dq_dir),
    .busy           (busy),
    .done           (done)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CK transition, held for two system clocks.
  task automatic ck_edge(input logic [7:0] dq, input logic rw);
    hram_dq_din   = dq;
    hram_rwds_din = rw;
    hram_ck       = ~hram_ck;
    tick();
    tick();
  endtask

  task automatic start(input logic [47:0] ca, input logic chk_ca);
    hram_cs = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      ck_edge(ca[47-8*i -: 8], 1'b0);
      if (chk_ca && i == 1) begin
        chk("ca_rwds", {29'd0, busy, hram_rwds_dir, hram_rwds_dout}, 32'h7);
        chk("ca_dq_dir", {31'd0, hram_dq_dir}, 32'h0);
      end
    end
    for (int i = 0; i < 4*LAT; i++) begin
      ck_edge(8'h00, 1'b0);
      if (i == 10) chk("lat_dq_dir", {31'd0, hram_dq_dir}, 32'h0);
    end
  endtask

  task automatic finish_xfer(input logic exp_done);
    hram_cs = 1'b1;
    hram_ck = 1'b0;
    tick();
    chk("end_done", {31'd0, done}, {31'd0, exp_done});
    chk("end_dirs", {29'd0, busy, hram_dq_dir, hram_rwds_dir}, 32'h0);
    tick();
    chk("done_once", {31'd0, done}, 32'h0);
  endtask

  task automatic write_burst(input logic [47:0] ca, input int nb);
    start(ca, 1'b0);
    for (int i = 0; i < nb; i++) begin
      ck_edge(wb[i], wm[i]);
    end
    chk("wr_dirs", {30'd0, hram_dq_dir, hram_rwds_dir}, 32'h0);
    finish_xfer(1'b1);
  endtask

  task automatic read_burst(input logic [47:0] ca, input int nw, input string tag);
    start(ca, 1'b0);
    chk({tag, "_pre"}, {20'd0, hram_dq_dir, hram_rwds_dir, hram_rwds_dout, 1'b0, hram_dq_dout},
        {20'd0, 1'b1, 1'b1, 1'b0, 1'b0, ew[0][15:8]});
    for (int w = 0; w < nw; w++) begin
      ck_edge(8'h00, 1'b0);
      chk({tag, "_hi"}, {23'd0, hram_rwds_dout, hram_dq_dout}, {23'd0, 1'b1, ew[w][15:8]});
      ck_edge(8'h00, 1'b0);
      chk({tag, "_lo"}, {23'd0, hram_rwds_dout, hram_dq_dout}, {23'd0, 1'b0, ew[w][7:0]});
    end
    finish_xfer(1'b1);
  endtask

  initial begin
    reset = 1'b1; hram_cs = 1'b1; hram_ck = 1'b0;
    hram_dq_din = 8'h00; hram_rwds_din = 1'b0;
    tick(); tick();
    chk("reset_out", {19'd0, busy, done, hram_dq_dir, hram_rwds_dir, hram_rwds_dout, hram_dq_dout}, 32'h0);
    reset = 1'b0;
    tick();

    // Write words 2,3 then read them back.
    wb[0] = 8'hAB; wb[1] = 8'hCD; wb[2] = 8'h12; wb[3] = 8'h34;
    for (int i = 0; i < 8; i++) wm[i] = 1'b0;
    start(48'h000000000002, 1'b1);
    for (int i = 0; i < 4; i++) ck_edge(wb[i], wm[i]);
    finish_xfer(1'b1);
    ew[0] = 16'hABCD; ew[1] = 16'h1234;
    read_burst(48'h800000000002, 2, "rd23");

    // Word 5 = 5566, then masked high-byte write of 77/88.
    wb[0] = 8'h55; wb[1] = 8'h66;
    write_burst(48'h000000000005, 2);
    wb[0] = 8'h77; wb[1] = 8'h88; wm[0] = 1'b1;
    write_burst(48'h000000000005, 2);
    wm[0] = 1'b0;
    ew[0] = 16'h5588;
    read_burst(48'h800000000005, 1, "mask5");

    // Words 0,1 (linear), 0x0F, 0xFF.
    wb[0] = 8'hA0; wb[1] = 8'h00; wb[2] = 8'hA0; wb[3] = 8'h01;
    write_burst(48'h200000000000, 4);
    wb[0] = 8'hF0; wb[1] = 8'h0F;
    write_burst(48'h000000010007, 2);
    wb[0] = 8'hBE; wb[1] = 8'hEF;
    write_burst(48'h0000001F0007, 2);
    ew[0] = 16'hF00F; ew[1] = 16'hA000; ew[2] = 16'hA001;
    read_burst(48'h800000010007, 3, "wrap0f");
    ew[0] = 16'hBEEF; ew[1] = 16'hA000;
    read_burst(48'hA000001F0007, 2, "lin_ff");

    // Register space: ID on read, writes discarded.
    ew[0] = 16'h0C81; ew[1] = 16'h0C81;
    read_burst(48'hC00000000002, 2, "regrd");
    wb[0] = 8'h99; wb[1] = 8'h99;
    write_burst(48'h400000000002, 2);
    ew[0] = 16'hABCD;
    read_burst(48'h800000000002, 1, "regwr");

    // Abort after three CA edges.
    hram_cs = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) ck_edge(8'h00, 1'b0);
    hram_cs = 1'b1; hram_ck = 1'b0;
    tick();
    chk("abort", {29'd0, busy, done, hram_rwds_dir}, 32'h0);
    tick();
    chk("abort_done", {31'd0, done}, 32'h0);

    // Reset on the first write-data edge to word 3.
    start(48'h000000000003, 1'b0);
    hram_dq_din = 8'h55; hram_rwds_din = 1'b0; hram_ck = ~hram_ck; reset = 1'b1;
    tick();
    chk("rst_wr", {19'd0, busy, done, hram_dq_dir, hram_rwds_dir, hram_rwds_dout, hram_dq_dout}, 32'h0);
    reset = 1'b0;
    tick(); tick();
    chk("rst_wait_cs", {31'd0, busy}, 32'h0);
    hram_cs = 1'b1; hram_ck = 1'b0;
    tick();
    ew[0] = 16'h1234;
    read_burst(48'h800000000003, 1, "rst_nowr");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
